// File: rtl/bist_pkg.sv
// Shared types and constants for the scan BIST pattern controller.
// Holds the controller state encoding and the 8-bit LFSR helpers.
package bist_pkg;

    localparam int unsigned SigWidth = 8;
    localparam logic [SigWidth-1:0] LfsrTaps = 8'hB8;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StCapture,
        StUnload,
        StFinish,
        StResult
    } state_t;

    // An all-zero LFSR never leaves zero, so a zero seed is replaced by 8'h01.
    function automatic logic [SigWidth-1:0] safe_seed(input logic [SigWidth-1:0] seed);
        return (seed == '0) ? 8'h01 : seed;
    endfunction

    // Tap mask bit 7 is x^8 and sits at the output end (bit 0) of the right-shifting
    // register, so the mask is applied to the bit-reversed state.
    function automatic logic [SigWidth-1:0] lfsr_next(input logic [SigWidth-1:0] cur);
        logic [SigWidth-1:0] rev;
        for (int i = 0; i < SigWidth; i++) begin
            rev[i] = cur[SigWidth-1-i];
        end
        return {^(rev & LfsrTaps), cur[SigWidth-1:1]};
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 8-bit Fibonacci pattern LFSR, shifting right with feedback into bit 7.
// Reset and load both apply the seed, with zero mapped to 8'h01.
module bist_lfsr
    import bist_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                advance,
    input  logic [SigWidth-1:0] seed,
    output logic [SigWidth-1:0] state
);

    logic [SigWidth-1:0] state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= safe_seed(seed);
        end else if (load) begin
            state_q <= safe_seed(seed);
        end else if (advance) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bist_pattern_ctrl.sv
// Scan BIST controller: shifts LFSR patterns through the CUT chain, steers MISR
// compaction, then compares the final signature against GOLDEN.
module bist_pattern_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned         SCAN_LEN   = 8,
    parameter int unsigned         N_PATTERNS = 16,
    parameter logic [SigWidth-1:0] SEED       = 8'h01,
    parameter logic [SigWidth-1:0] GOLDEN     = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SigWidth-1:0] signature,
    output logic                scan_en,
    output logic                scan_in,
    output logic                grant_o,
    output logic                finish,
    output logic                busy,
    output logic                done,
    output logic                pass
);

    localparam int unsigned BitW = $clog2(SCAN_LEN + 1);
    localparam int unsigned PatW = $clog2(N_PATTERNS + 1);
    localparam logic [BitW-1:0] LastBit = BitW'(SCAN_LEN - 1);
    localparam logic [PatW-1:0] NumPat  = PatW'(N_PATTERNS);

    state_t              state_q, state_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [PatW-1:0]     pat_cnt_q, pat_cnt_d;
    logic [PatW-1:0]     pat_next;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                lfsr_load;
    logic                lfsr_adv;
    logic [SigWidth-1:0] lfsr_state;
    logic                unused_lfsr;

    bist_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .seed    (SEED),
        .state   (lfsr_state)
    );

    // Only bit 0 feeds the chain; the upper bits exist for the shift itself.
    assign unused_lfsr = ^lfsr_state[SigWidth-1:1];
    assign pat_next    = pat_cnt_q + PatW'(1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pat_cnt_d = pat_cnt_q;
        done_d    = done_q;
        pass_d    = pass_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        scan_en   = 1'b0;
        scan_in   = 1'b0;
        grant_o   = 1'b0;
        finish    = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    bit_cnt_d = '0;
                    pat_cnt_d = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                busy     = 1'b1;
                scan_en  = 1'b1;
                scan_in  = lfsr_state[0];
                // The chain still holds the previous response except on the first pattern.
                grant_o  = (pat_cnt_q != '0);
                lfsr_adv = 1'b1;
                if (bit_cnt_q == LastBit) begin
                    bit_cnt_d = '0;
                    state_d   = StCapture;
                end else begin
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                end
            end
            StCapture: begin
                busy      = 1'b1;
                pat_cnt_d = pat_next;
                state_d   = (pat_next < NumPat) ? StShift : StUnload;
            end
            StUnload: begin
                busy    = 1'b1;
                scan_en = 1'b1;
                grant_o = 1'b1;
                if (bit_cnt_q == LastBit) begin
                    bit_cnt_d = '0;
                    state_d   = StFinish;
                end else begin
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                end
            end
            StFinish: begin
                busy    = 1'b1;
                finish  = 1'b1;
                state_d = StResult;
            end
            StResult: begin
                done_d  = 1'b1;
                pass_d  = (signature == GOLDEN);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            pat_cnt_q <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            pat_cnt_q <= pat_cnt_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Directed bench for bist_pattern_ctrl: cycle traces of full runs against
// hand-derived masks, plus a long-chain instance for the LFSR period.
module tb_bist_pattern_ctrl;

    localparam logic [7:0] Gold = 8'h5A;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] signature;
    logic       scan_en, scan_in, grant_o, finish, busy, done, pass;

    logic       start_l;
    logic       scan_en_l, scan_in_l, grant_l, finish_l, busy_l, done_l, pass_l;

    logic       start_z;
    logic       scan_en_z, scan_in_z, grant_z, finish_z, busy_z, done_z, pass_z;

    int checks   = 0;
    int failures = 0;

    logic [63:0] en_v, in_v, gr_v, fin_v, busy_v, done_v, pass_v;

    always #5 clk = ~clk;

    bist_pattern_ctrl #(
        .SCAN_LEN   (8),
        .N_PATTERNS (2),
        .SEED       (8'h01),
        .GOLDEN     (Gold)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signature (signature),
        .scan_en   (scan_en),
        .scan_in   (scan_in),
        .grant_o   (grant_o),
        .finish    (finish),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
    );

    bist_pattern_ctrl #(
        .SCAN_LEN   (255),
        .N_PATTERNS (1),
        .SEED       (8'h01),
        .GOLDEN     (8'h00)
    ) dut_long (
        .clk       (clk),
        .rst       (rst),
        .start     (start_l),
        .signature (signature),
        .scan_en   (scan_en_l),
        .scan_in   (scan_in_l),
        .grant_o   (grant_l),
        .finish    (finish_l),
        .busy      (busy_l),
        .done      (done_l),
        .pass      (pass_l)
    );

    bist_pattern_ctrl #(
        .SCAN_LEN   (1),
        .N_PATTERNS (1),
        .SEED       (8'h00),
        .GOLDEN     (8'h00)
    ) dut_zero (
        .clk       (clk),
        .rst       (rst),
        .start     (start_z),
        .signature (signature),
        .scan_en   (scan_en_z),
        .scan_in   (scan_in_z),
        .grant_o   (grant_z),
        .finish    (finish_z),
        .busy      (busy_z),
        .done      (done_z),
        .pass      (pass_z)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Samples n negedges; start drops after the first sample unless held.
    task automatic capture(input int n, input bit hold);
        en_v = '0; in_v = '0; gr_v = '0; fin_v = '0; busy_v = '0; done_v = '0; pass_v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en_v[i]   = scan_en;
            in_v[i]   = scan_in;
            gr_v[i]   = grant_o;
            fin_v[i]  = finish;
            busy_v[i] = busy;
            done_v[i] = done;
            pass_v[i] = pass;
            if (!hold) start = 1'b0;
        end
        start = 1'b0;
    endtask

    // One 27-cycle run: SHIFT 0-7, CAPTURE 8, SHIFT 9-16, CAPTURE 17,
    // UNLOAD 18-25, FINISH 26, RESULT 27, IDLE with done at 28.
    task automatic check_run(input string tag, input logic exp_pass);
        check_eq({tag, "_busy"}, busy_v & mask(0, 28), mask(0, 26));
        check_eq({tag, "_scan_en"}, en_v & mask(0, 28), mask(0, 7) | mask(9, 16) | mask(18, 25));
        check_eq({tag, "_grant"}, gr_v & mask(0, 28), mask(9, 16) | mask(18, 25));
        check_eq({tag, "_finish"}, fin_v & mask(0, 28), mask(26, 26));
        check_eq({tag, "_first_pattern"}, {56'h0, in_v[7:0]}, 64'h01);
        check_eq({tag, "_scan_in_idle"}, in_v & ~(mask(0, 7) | mask(9, 16)) & mask(0, 28), 64'h0);
        check_eq({tag, "_done"}, done_v & mask(0, 28), mask(28, 28));
        check_eq({tag, "_pass"}, {63'h0, pass_v[28]}, {63'h0, exp_pass});
    endtask

    initial begin
        int   n_adv;
        int   first_ret;
        int   busy_cnt;
        logic first_bit;
        logic got_first;

        rst = 1'b0; start = 1'b0; start_l = 1'b0; start_z = 1'b0; signature = Gold;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", {57'h0, scan_en, scan_in, grant_o, finish, busy, done, pass}, 64'h0);
        check_eq("reset_lfsr", {56'h0, dut.u_lfsr.state}, 64'h01);
        check_eq("reset_zero_seed_lfsr", {56'h0, dut_zero.u_lfsr.state}, 64'h01);
        rst = 1'b1;
        @(negedge clk);

        start = 1'b1;
        capture(29, 1'b0);
        check_run("run_pass", 1'b1);
        repeat (5) @(negedge clk);
        check_eq("done_pass_held", {62'h0, done, pass}, 64'h3);

        signature = Gold ^ 8'h01;
        start = 1'b1;
        capture(29, 1'b0);
        check_run("run_fail", 1'b0);

        // Reset pulse in the second SHIFT (index 11).
        signature = Gold;
        start = 1'b1;
        capture(12, 1'b0);
        check_eq("pre_reset_grant", {63'h0, gr_v[11]}, 64'h1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrun_reset_outputs",
                 {57'h0, scan_en, scan_in, grant_o, finish, busy, done, pass}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        capture(29, 1'b0);
        check_run("run_after_reset", 1'b1);

        // Held start: second run begins right after the RESULT and IDLE cycles.
        start = 1'b1;
        capture(58, 1'b1);
        check_eq("held_busy", busy_v & mask(0, 57), mask(0, 26) | mask(29, 55));
        check_eq("held_finish", fin_v & mask(0, 57), mask(26, 26) | mask(55, 55));
        check_eq("held_done", done_v & mask(0, 57), mask(28, 28) | mask(57, 57));

        // Long chain: one 255-bit pattern walks the whole LFSR period.
        n_adv = 0; first_ret = 0; busy_cnt = 0; first_bit = 1'b0; got_first = 1'b0;
        start_l = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            start_l = 1'b0;
            if (busy_l) begin
                busy_cnt++;
                if (!got_first) begin
                    first_bit = scan_in_l;
                    got_first = 1'b1;
                end
                if (n_adv > 0 && first_ret == 0 && dut_long.u_lfsr.state == 8'h01) begin
                    first_ret = n_adv;
                end
                if (scan_en_l && !grant_l) n_adv++;
            end
            if (done_l) break;
        end
        check_eq("long_done", {63'h0, done_l}, 64'h1);
        check_eq("long_first_bit", {63'h0, first_bit}, 64'h1);
        check_eq("long_advances", 64'(n_adv), 64'd255);
        check_eq("long_period", 64'(first_ret), 64'd255);
        check_eq("long_lfsr_final", {56'h0, dut_long.u_lfsr.state}, 64'h01);
        check_eq("long_busy_cycles", 64'(busy_cnt), 64'd512);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bist_pattern_ctrl.md
BIST_PATTERN_CTRL -- requirements
Module: bist_pattern_ctrl

Interface
REQ-001 SHALL have parameter SCAN_LEN, default 8, scan chain length in bits (1..255).
REQ-002 SHALL have parameter N_PATTERNS, default 16, number of test patterns per run (1..65535).
REQ-003 SHALL have parameter SEED, default 8'h01, LFSR load value.
REQ-004 SHALL have parameter GOLDEN, default 8'h00, expected MISR signature.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous and active-low.
REQ-007 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-008 SHALL have port signature  input  8  MISR signature.
REQ-009 SHALL have port scan_en  output  1  CUT scan-shift enable.
REQ-010 SHALL have port scan_in  output  1  serial pattern bit to the CUT chain.
REQ-011 SHALL have port grant_o  output  1  MISR compaction enable.
REQ-012 SHALL have port finish  output  1  one-cycle pulse that freezes the MISR.
REQ-013 SHALL have port busy  output  1  high from the first SHIFT cycle through FINISH.
REQ-014 SHALL have port done  output  1  result valid; held until the next start.
REQ-015 SHALL have port pass  output  1  signature==GOLDEN; valid only when done=1.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, CAPTURE, UNLOAD, FINISH, RESULT.
REQ-017 IDLE with start=1 SHALL load LFSR=SEED, clear the bit and pattern counters, clear done/pass, and enter SHIFT next cycle.
REQ-018 SHIFT SHALL drive scan_en=1, scan_in=lfsr[0], and advance the LFSR and bit counter each cycle; after SCAN_LEN cycles it SHALL enter CAPTURE.
REQ-019 grant_o SHALL be 1 in SHIFT for patterns 2..N_PATTERNS only, so the previous response is compacted; it SHALL be 0 for the first pattern.
REQ-020 CAPTURE SHALL last exactly 1 cycle with scan_en=0 and grant_o=0, then increment the pattern counter.
REQ-021 On leaving CAPTURE, the FSM SHALL enter SHIFT if patterns done < N_PATTERNS, else UNLOAD.
REQ-022 UNLOAD SHALL last SCAN_LEN cycles with scan_en=1, grant_o=1 and scan_in=0; the LFSR SHALL hold.
REQ-023 FINISH SHALL last 1 cycle with finish=1 and all other scan outputs 0, then enter RESULT.
REQ-024 RESULT SHALL register pass=(signature==GOLDEN) and set done=1, then return to IDLE; done and pass SHALL hold until the next accepted start.
REQ-025 Run length in busy cycles SHALL be N_PATTERNS*(SCAN_LEN+1)+SCAN_LEN+1.
REQ-026 The LFSR SHALL be 8-bit Fibonacci with polynomial x^8+x^6+x^5+x^4+1 (maximal, period 255); it SHALL shift right with the feedback bit entering bit 7.
REQ-027 If SEED==0, the LFSR SHALL load 8'h01 to avoid lock-up.
REQ-028 start while busy=1 or in RESULT SHALL be ignored.
REQ-029 Counters SHALL be sized from SCAN_LEN and N_PATTERNS and SHALL never wrap within a run.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE, LFSR=SEED (or 8'h01 if SEED==0), counters=0, and all outputs 0; this SHALL apply mid-run too.
REQ-031 The first start after reset release SHALL be accepted normally.

Structure
REQ-032 Package bist_pkg SHALL hold the state enum, the 8-bit signature width constant, and the LFSR tap mask 8'hB8.
REQ-033 The LFSR SHALL be a separate sub-module bist_lfsr with ports clk, rst, load, advance, seed, and state.

Verification
REQ-034 SCAN_LEN=8, N_PATTERNS=2, start pulse -> busy high exactly 27 cycles; scan_en pattern is 8 high, 1 low, 8 high, 1 low, 8 high; one finish pulse.
REQ-035 SEED=8'h01 -> first scan_in bit is 1; the LFSR state returns to 8'h01 after exactly 255 advances (bench with SCAN_LEN=255, N_PATTERNS=1).
REQ-036 grant_o -> 0 during the first SHIFT; 1 during the second SHIFT and UNLOAD; 0 in CAPTURE and FINISH.
REQ-037 signature driven to GOLDEN at RESULT -> done=1, pass=1; signature=GOLDEN^8'h01 -> done=1, pass=0.
REQ-038 rst=0 for one cycle during the second SHIFT -> all outputs 0 next cycle, and a fresh start yields a full 27-cycle run.
REQ-039 start held high continuously -> runs execute back-to-back, each separated by RESULT and IDLE cycles, with no mid-run restart.
